// File: rtl/instruction_encoder_pkg.sv
// Shared encoder definitions: opcodes, ALU operations, request kinds, field positions and ranges.
// Ports: none (package). Imported by instr_pack and instruction_encoder.
// The range helper treats an immediate as legal when it sign-extends from the given width.
package instruction_encoder_pkg;

  typedef logic [31:0] data_t;

  localparam logic [2:0] OPCODE_R    = 3'd0;
  localparam logic [2:0] OPCODE_I    = 3'd1;
  localparam logic [2:0] OPCODE_F    = 3'd2;
  localparam logic [2:0] OPCODE_M    = 3'd3;
  localparam logic [2:0] OPCODE_J    = 3'd4;
  localparam logic [2:0] OPCODE_UP   = 3'd5;
  localparam logic [2:0] OPCODE_HALT = 3'd7;

  // Encodings 28..31 are deliberately unassigned and are rejected as illegal.
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_MUL, ALU_DIV, ALU_SLT, ALU_SLL, ALU_SEQ, ALU_SNEZ, ALU_MIN, ALU_ABS,
    ALU_ADDI = 5'd10, ALU_MULI, ALU_DIVI, ALU_SLLI,
    ALU_FADD = 5'd14, ALU_FSUB, ALU_FMUL, ALU_FDIV, ALU_FMIN, ALU_FMAX, ALU_FSQRT,
    ALU_FEQ, ALU_FLT, ALU_FLE, ALU_FCVT_S_W,
    ALU_JAL = 5'd25, ALU_BEQZ, ALU_SYNC
  } alu_instruction_t;

  typedef enum logic [2:0] {
    K_ALU  = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_FLW = 3'd3,
    K_FSW  = 3'd4, K_LUI = 3'd5, K_HALT = 3'd6
  } instr_kind_t;

  // Field positions
  localparam int OPCODE_LSB   = 29;
  localparam int RD_LSB       = 0;
  localparam int RS1_LSB      = 5;
  localparam int RS2_LSB      = 14;
  localparam int FUNCT4_LSB   = 10;
  localparam int J_FUNCT3_LSB = 12;
  localparam int M_FUNCT3_LSB = 10;
  localparam int SCALAR_RIF   = 28;
  localparam int SCALAR_M     = 13;
  localparam int SCALAR_UP    = 5;

  // Signed immediate widths that must hold the value
  localparam int unsigned IMM_I_BITS   = 14;
  localparam int unsigned IMM_MEM_BITS = 15;
  localparam int unsigned IMM_BR_BITS  = 18;
  localparam int unsigned IMM_JAL_BITS = 28;

  function automatic logic fits_signed(input data_t v, input int unsigned bits);
    data_t hi;
    hi = data_t'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_pack.sv
// Combinational packing of one request into a 32-bit instruction word plus a legality flag.
// Ports: kind/alu_op/rd/rs1/rs2/imm/scalar in; word, legal out. Pure combinational, no clock.
// Fields are written funct, registers, immediate, scalar so later fields win on overlap.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  instr_kind_t      kind,
  input  alu_instruction_t alu_op,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  data_t            imm,
  input  logic             scalar,
  output data_t            word,
  output logic             legal
);

  logic [4:0] op_n;
  assign op_n = alu_op;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      K_ALU: begin
        case (alu_op) inside
          [ALU_ADD:ALU_ABS]: begin
            word[31:OPCODE_LSB]           = OPCODE_R;
            word[FUNCT4_LSB +: 4]         = op_n[3:0];
            word[RD_LSB +: 5]             = rd;
            word[RS1_LSB +: 5]            = rs1;
            word[RS2_LSB +: 5]            = rs2;
            word[SCALAR_RIF]              = scalar;
          end
          [ALU_ADDI:ALU_SLLI]: begin
            word[31:OPCODE_LSB] = OPCODE_I;
            case (alu_op)
              ALU_MULI: word[FUNCT4_LSB +: 4] = 4'd2;
              ALU_DIVI: word[FUNCT4_LSB +: 4] = 4'd3;
              ALU_SLLI: word[FUNCT4_LSB +: 4] = 4'd10;
              default:  word[FUNCT4_LSB +: 4] = 4'd0;
            endcase
            word[RD_LSB +: 5]  = rd;
            word[RS1_LSB +: 5] = rs1;
            word[27:14]        = imm[13:0];
            word[SCALAR_RIF]   = scalar;
            legal              = fits_signed(imm, IMM_I_BITS);
          end
          [ALU_FADD:ALU_FCVT_S_W]: begin
            word[31:OPCODE_LSB]   = OPCODE_F;
            word[FUNCT4_LSB +: 4] = 4'(op_n - 5'(ALU_FADD));
            word[RD_LSB +: 5]     = rd;
            word[RS1_LSB +: 5]    = rs1;
            word[RS2_LSB +: 5]    = rs2;
            word[SCALAR_RIF]      = scalar;
          end
          ALU_JAL: begin
            // The 26-bit offset covers funct3 and rd entirely.
            word[31:OPCODE_LSB]     = OPCODE_J;
            word[J_FUNCT3_LSB +: 3] = 3'b000;
            word[RD_LSB +: 5]       = rd;
            word[28:13]             = imm[27:12];
            word[9:0]               = imm[11:2];
            legal = fits_signed(imm, IMM_JAL_BITS) && (imm[1:0] == 2'b00);
          end
          ALU_BEQZ: begin
            word[31:OPCODE_LSB]     = OPCODE_J;
            word[J_FUNCT3_LSB +: 3] = 3'b001;
            word[RS1_LSB +: 5]      = rs1;
            word[28:19]             = imm[17:8];
            word[13]                = imm[7];
            word[4:0]               = imm[6:2];
            legal = fits_signed(imm, IMM_BR_BITS) && (imm[1:0] == 2'b00);
          end
          ALU_SYNC: begin
            word[31:OPCODE_LSB]     = OPCODE_J;
            word[J_FUNCT3_LSB +: 3] = 3'b110;
          end
          default: legal = 1'b0;
        endcase
      end
      // Memory funct3 sits at [12:10]; bits 13/14 belong to the scalar bit and immediate.
      K_LW, K_FLW: begin
        word[31:OPCODE_LSB]     = OPCODE_M;
        word[M_FUNCT3_LSB +: 3] = (kind == K_FLW) ? 3'b010 : 3'b000;
        word[RD_LSB +: 5]       = rd;
        word[RS1_LSB +: 5]      = rs1;
        word[28:14]             = imm[14:0];
        word[SCALAR_M]          = scalar;
        legal                   = fits_signed(imm, IMM_MEM_BITS);
      end
      K_SW, K_FSW: begin
        word[31:OPCODE_LSB]     = OPCODE_M;
        word[M_FUNCT3_LSB +: 3] = (kind == K_FSW) ? 3'b011 : 3'b001;
        word[RS1_LSB +: 5]      = rs1;
        word[RS2_LSB +: 5]      = rs2;
        word[28:19]             = imm[14:5];
        word[4:0]               = imm[4:0];
        word[SCALAR_M]          = scalar;
        legal                   = fits_signed(imm, IMM_MEM_BITS);
      end
      K_LUI: begin
        word[31:OPCODE_LSB] = OPCODE_UP;
        word[RD_LSB +: 5]   = rd;
        word[28:9]          = imm[31:12];
        word[SCALAR_UP]     = scalar;
        legal               = (imm[11:0] == 12'd0);
      end
      K_HALT: word[31:OPCODE_LSB] = OPCODE_HALT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts instruction requests, encodes them and writes each word to sequential instruction-memory addresses.
// Ports: clk/reset, in_* request handshake, load_addr*, mem_write_* write port, err_illegal, instr_count.
// Latency 1 from accept to mem_write_valid; in_ready drops while a word waits for mem_write_ready.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instr_kind_t           in_kind,
  input  alu_instruction_t      in_alu_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  data_t                 in_imm,
  input  logic                  in_scalar,
  input  logic                  load_addr_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  mem_write_valid,
  input  logic                  mem_write_ready,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  err_illegal,
  output logic [15:0]           instr_count
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t state, state_nxt;
  data_t  pack_word;
  logic   pack_legal;
  logic   accept;

  instr_pack u_pack (
    .kind   (in_kind),
    .alu_op (in_alu_op),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .scalar (in_scalar),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign in_ready        = (state == S_IDLE);
  assign mem_write_valid = (state == S_WRITE);
  assign accept          = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && pack_legal) state_nxt = S_WRITE;
      S_WRITE: if (mem_write_ready)      state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address load and increment happen in different states, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write_address <= '0;
      mem_write_data    <= '0;
      err_illegal       <= 1'b0;
      instr_count       <= '0;
    end else begin
      err_illegal <= accept && !pack_legal;
      if (in_ready && load_addr_valid) mem_write_address <= load_addr;
      if (accept && pack_legal)        mem_write_data    <= pack_word;
      if (mem_write_valid && mem_write_ready) begin
        mem_write_address <= mem_write_address + 1'b1;
        instr_count       <= instr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  instr_kind_t      in_kind;
  alu_instruction_t in_alu_op;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  data_t            in_imm;
  logic             in_scalar;
  logic             load_addr_valid;
  logic [7:0]       load_addr;
  logic             mem_write_valid;
  logic             mem_write_ready;
  logic [7:0]       mem_write_address;
  logic [31:0]      mem_write_data;
  logic             err_illegal;
  logic [15:0]      instr_count;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_addr  = 8'd0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_scalar(in_scalar),
    .load_addr_valid(load_addr_valid), .load_addr(load_addr),
    .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .err_illegal(err_illegal), .instr_count(instr_count)
  );

  function automatic logic [31:0] opc(input logic [2:0] o);
    return {o, 29'd0};
  endfunction

  // Reference encoder built directly from the field table with integer arithmetic.
  function automatic void ref_encode(input int kind, input int op, input int rd, input int rs1,
                                     input int rs2, input int imm, input int sc,
                                     output bit legal, output logic [31:0] w);
    int fi[4] = '{0, 2, 3, 10};
    legal = 0;
    w = 0;
    if (kind == 0) begin
      if (op <= 9) begin
        legal = 1;
        w = opc(OPCODE_R) | (op << 10) | rd | (rs1 << 5) | (rs2 << 14) | (sc << 28);
      end else if (op <= 13) begin
        legal = (imm >= -8192) && (imm <= 8191);
        w = opc(OPCODE_I) | (fi[op-10] << 10) | rd | (rs1 << 5) | ((imm & 32'h3FFF) << 14) | (sc << 28);
      end else if (op <= 24) begin
        legal = 1;
        w = opc(OPCODE_F) | ((op - 14) << 10) | rd | (rs1 << 5) | (rs2 << 14) | (sc << 28);
      end else if (op == 25) begin
        legal = (imm >= -134217728) && (imm <= 134217727) && ((imm & 3) == 0);
        w = opc(OPCODE_J) | (((imm >> 12) & 32'hFFFF) << 13) | ((imm >> 2) & 32'h3FF);
      end else if (op == 26) begin
        legal = (imm >= -131072) && (imm <= 131071) && ((imm & 3) == 0);
        w = opc(OPCODE_J) | (1 << 12) | (rs1 << 5) | (((imm >> 8) & 32'h3FF) << 19)
            | (((imm >> 7) & 1) << 13) | ((imm >> 2) & 32'h1F);
      end else if (op == 27) begin
        legal = 1;
        w = opc(OPCODE_J) | (6 << 12);
      end
    end else if (kind == 1 || kind == 3) begin
      legal = (imm >= -16384) && (imm <= 16383);
      w = opc(OPCODE_M) | ((kind == 3 ? 2 : 0) << 10) | rd | (rs1 << 5) | ((imm & 32'h7FFF) << 14) | (sc << 13);
    end else if (kind == 2 || kind == 4) begin
      legal = (imm >= -16384) && (imm <= 16383);
      w = opc(OPCODE_M) | ((kind == 4 ? 3 : 1) << 10) | (rs1 << 5) | (rs2 << 14)
          | (((imm >> 5) & 32'h3FF) << 19) | (imm & 32'h1F) | (sc << 13);
    end else if (kind == 5) begin
      legal = ((imm & 32'hFFF) == 0);
      w = opc(OPCODE_UP) | rd | (((imm >> 12) & 32'hFFFFF) << 9) | (sc << 5);
    end else if (kind == 6) begin
      legal = 1;
      w = opc(OPCODE_HALT);
    end
  endfunction

  // Drives one request (always presented while in_ready is high) and completes any write after 'stall' cycles.
  task automatic issue(input int kind, input int op, input int rd, input int rs1, input int rs2,
                       input int imm, input int sc, input bit ld_v, input logic [7:0] ld_a,
                       input int stall, output logic o_valid, output logic o_err,
                       output logic [7:0] o_addr, output logic [31:0] o_data);
    in_kind         = instr_kind_t'(kind[2:0]);
    in_alu_op       = alu_instruction_t'(op[4:0]);
    in_rd           = rd[4:0];
    in_rs1          = rs1[4:0];
    in_rs2          = rs2[4:0];
    in_imm          = imm;
    in_scalar       = sc[0];
    load_addr_valid = ld_v;
    load_addr       = ld_a;
    mem_write_ready = 1'b0;
    in_valid        = 1'b1;
    @(posedge clk); #1;
    in_valid        = 1'b0;
    load_addr_valid = 1'b0;
    o_valid = mem_write_valid;
    o_err   = err_illegal;
    o_addr  = mem_write_address;
    o_data  = mem_write_data;
    if (o_valid) begin
      repeat (stall) begin @(posedge clk); #1; end
      mem_write_ready = 1'b1;
      @(posedge clk); #1;
      mem_write_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; load_addr_valid = 1'b0; load_addr = '0;
    mem_write_ready = 1'b0; in_kind = K_ALU; in_alu_op = ALU_ADD;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_scalar = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (mem_write_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mem_write_valid); end
    checks++; if (mem_write_address !== 8'd0) begin errors++; $display("FAIL reset_addr got %h want 00", mem_write_address); end
    checks++; if (mem_write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", mem_write_data); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_illegal); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic v, e; logic [7:0] a; logic [31:0] d;
    issue(K_ALU, ALU_ADD, 3, 1, 2, 0, 1, 0, 8'h00, 0, v, e, a, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL add_latency valid got %b want 1", v); end
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL add_addr got %h want 00", a); end
    checks++; if (d !== (opc(OPCODE_R) | 32'h10008023)) begin errors++; $display("FAIL add_data got %h want %h", d, opc(OPCODE_R) | 32'h10008023); end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d want 1", instr_count); end
    issue(K_ALU, ALU_ADDI, 1, 2, 0, -1, 0, 0, 8'h00, 1, v, e, a, d);
    checks++; if (d !== (opc(OPCODE_I) | 32'h0FFFC041) || a !== 8'h01) begin errors++; $display("FAIL addi_data got %h@%h want %h@01", d, a, opc(OPCODE_I) | 32'h0FFFC041); end
    issue(K_ALU, ALU_ADDI, 1, 2, 0, 8192, 0, 0, 8'h00, 0, v, e, a, d);
    checks++; if (e !== 1'b1 || v !== 1'b0) begin errors++; $display("FAIL addi_range err=%b valid=%b want err=1 valid=0", e, v); end
    @(posedge clk); #1;
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", err_illegal); end
    checks++; if (mem_write_address !== 8'h02 || instr_count !== 16'd2) begin errors++; $display("FAIL illegal_nowrite addr=%h count=%0d want 02/2", mem_write_address, instr_count); end
    issue(K_LUI, 0, 4, 0, 0, 32'h12345000, 1, 0, 8'h00, 0, v, e, a, d);
    checks++; if (d !== (opc(OPCODE_UP) | 32'h02468A24) || a !== 8'h02) begin errors++; $display("FAIL lui_data got %h@%h want %h@02", d, a, opc(OPCODE_UP) | 32'h02468A24); end
    exp_addr  = 8'h03;
    exp_count = 16'd3;
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    want = opc(OPCODE_R) | (1 << 10) | 7 | (8 << 5) | (9 << 14);
    in_kind = K_ALU; in_alu_op = ALU_SUB; in_rd = 5'd7; in_rs1 = 5'd8; in_rs2 = 5'd9;
    in_imm = '0; in_scalar = 1'b0; mem_write_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_write_valid !== 1'b1 || in_ready !== 1'b0 || mem_write_address !== exp_addr || mem_write_data !== want) begin
        errors++;
        $display("FAIL stall_hold cyc%0d valid=%b ready=%b addr=%h data=%h want 1/0/%h/%h",
                 i, mem_write_valid, in_ready, mem_write_address, mem_write_data, exp_addr, want);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    mem_write_ready = 1'b1;
    @(posedge clk); #1;
    mem_write_ready = 1'b0;
    exp_addr++; exp_count++;
    @(posedge clk); #1;
    checks++;
    if (mem_write_valid !== 1'b0 || instr_count !== exp_count || mem_write_address !== exp_addr) begin
      errors++;
      $display("FAIL stall_single valid=%b count=%0d addr=%h want 0/%0d/%h", mem_write_valid, instr_count, mem_write_address, exp_count, exp_addr);
    end
  endtask

  task automatic test_load_addr();
    logic v, e; logic [7:0] a; logic [31:0] d;
    issue(K_HALT, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 0, v, e, a, d);
    checks++; if (a !== 8'hFF || d !== opc(OPCODE_HALT)) begin errors++; $display("FAIL load_addr got %h/%h want ff/%h", a, d, opc(OPCODE_HALT)); end
    issue(K_ALU, ALU_SYNC, 0, 0, 0, 0, 0, 0, 8'h00, 0, v, e, a, d);
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL addr_wrap got %h want 00", a); end
    exp_addr  = 8'h01;
    exp_count = exp_count + 16'd2;
  endtask

  task automatic test_random();
    int edges[14] = '{8191, 8192, -8192, -8193, 16383, 16384, -16384, -16385,
                      131068, 131072, -131072, 134217724, -134217728, 134217728};
    for (int n = 0; n < 80; n++) begin
      int kind, op, imm, mode;
      bit ld_v, legal;
      logic [7:0] ld_a, a;
      logic [31:0] w, d;
      logic v, e;
      kind = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 0;
      op   = $urandom_range(0, 31);
      mode = $urandom_range(0, 4);
      case (mode)
        0: imm = $urandom_range(0, 400) - 200;
        1: imm = $urandom;
        2: imm = edges[$urandom_range(0, 13)];
        3: imm = ($urandom_range(0, 262143) - 131072) & ~3;
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      ld_v = ($urandom_range(0, 9) == 0);
      ld_a = 8'($urandom);
      if (ld_v) exp_addr = ld_a;
      ref_encode(kind, op, 0, 0, 0, 0, 0, legal, w);
      begin
        int rd, rs1, rs2, sc;
        rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31); sc = $urandom_range(0, 1);
        ref_encode(kind, op, rd, rs1, rs2, imm, sc, legal, w);
        issue(kind, op, rd, rs1, rs2, imm, sc, ld_v, ld_a, $urandom_range(0, 3), v, e, a, d);
      end
      if (legal) begin
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || a !== exp_addr || d !== w) begin
          errors++;
          $display("FAIL rand_write n=%0d k=%0d op=%0d imm=%0d got v=%b e=%b %h@%h want %h@%h",
                   n, kind, op, imm, v, e, d, a, w, exp_addr);
        end
        exp_addr++; exp_count++;
        checks++;
        if (instr_count !== exp_count) begin errors++; $display("FAIL rand_count got %0d want %0d", instr_count, exp_count); end
      end else begin
        checks++;
        if (v !== 1'b0 || e !== 1'b1) begin
          errors++;
          $display("FAIL rand_illegal n=%0d k=%0d op=%0d imm=%0d got v=%b e=%b want 0/1", n, kind, op, imm, v, e);
        end
        @(posedge clk); #1;
        checks++;
        if (err_illegal !== 1'b0 || mem_write_address !== exp_addr) begin
          errors++;
          $display("FAIL rand_after_illegal err=%b addr=%h want 0/%h", err_illegal, mem_write_address, exp_addr);
        end
      end
    end
  endtask

  task automatic test_reset_in_write();
    in_kind = K_LW; in_alu_op = ALU_ADD; in_imm = 32'd12; in_valid = 1'b1; mem_write_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (mem_write_valid !== 1'b1) begin errors++; $display("FAIL rst_write_enter got %b want 1", mem_write_valid); end
    reset = 1'b1;
    mem_write_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_write_ready = 1'b0;
    checks++;
    if (mem_write_valid !== 1'b0 || mem_write_address !== 8'h00 || instr_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_write valid=%b addr=%h count=%0d ready=%b want 0/00/0/1",
               mem_write_valid, mem_write_address, instr_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_load_addr();
    test_random();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, instruction-memory word-address width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an instruction request is presented.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 in_kind  input  instr_kind_t  one of K_ALU, K_LW, K_SW, K_FLW, K_FSW, K_LUI, K_HALT.
REQ-007 in_alu_op  input  alu_instruction_t  operation when in_kind=K_ALU.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register addresses.
REQ-009 in_imm  input  data_t  full-width signed immediate or byte offset.
REQ-010 in_scalar  input  1  scalar (1) or vector (0) instruction.
REQ-011 load_addr_valid  input  1; load_addr  input  ADDR_WIDTH  set the next write address.
REQ-012 mem_write_valid  output  1; mem_write_ready  input  1; mem_write_address  output  ADDR_WIDTH; mem_write_data  output  32  instruction-memory write port.
REQ-013 err_illegal  output  1  one-cycle pulse: accepted request was not encodable.
REQ-014 instr_count  output  16  number of words written since reset, wraps at 2^16.

Function
REQ-015 FSM states IDLE, WRITE; in_ready=1 only in IDLE.
REQ-016 IDLE: in_valid=1 and request encodable -> register word, go WRITE; mem_write_valid=1 in the following cycle (latency 1).
REQ-017 WRITE: hold mem_write_valid, address and data stable until mem_write_ready=1; on that cycle increment address (wrap 2^ADDR_WIDTH-1 -> 0), increment instr_count, return to IDLE.
REQ-018 Unencodable accepted request: no write, err_illegal=1 next cycle, remain IDLE, address unchanged.
REQ-019 load_addr_valid honored only in IDLE; simultaneous with accepted request -> that request is written at load_addr.
REQ-020 Opcode [31:29] from shared OPCODE_* constants: R-ops (ADD,SUB,MUL,DIV,SLT,SLL,SEQ,SNEZ,MIN,ABS) funct4 0-9 at [13:10]; I-ops ADDI/MULI/DIVI/SLLI funct4 0/2/3/10; F-ops FADD..FCVT_S_W funct4 0-10; JAL/BEQZ/SYNC OPCODE_J funct3 [14:12] 000/001/110; loads funct3 000 (LW)/010 (FLW), stores 001 (SW)/011 (FSW) under OPCODE_M; K_LUI OPCODE_UP; K_HALT OPCODE_HALT, other bits 0.
REQ-021 Field placement: rd [4:0], rs1 [9:5], rs2 [18:14]; imm_i [27:14]; load imm [28:14]; store imm {[28:19],[4:0]}; branch imm[17:2] -> {[28:19],[13],[4:0]}; JAL imm[27:2] -> {[28:13],[9:0]}; LUI imm[31:12] -> [28:9].
REQ-022 Scalar bit: [28] for R/I/F; [13] for M; [5] for LUI; ignored otherwise.
REQ-023 Overlapping bits: write order funct, registers, immediate, scalar bit; the later field wins.
REQ-024 Encodable ranges: imm_i -8192..8191; load/store -16384..16383; branch 18-bit signed, imm[1:0]=0; JAL 28-bit signed, imm[1:0]=0; LUI imm[11:0]=0; any other alu_op under K_ALU illegal.
REQ-025 Unused fields are 0.

Reset
REQ-026 Reset -> IDLE, mem_write_valid=0, mem_write_address=0, mem_write_data=0, err_illegal=0, instr_count=0, in_ready=1 next cycle.
REQ-027 Reset during WRITE abandons the word; no write completes.

Structure
REQ-028 instr_kind_t and field-position/range constants SHALL live in the shared common package beside OPCODE_* and alu_instruction_t.
REQ-029 Combinational packing and range check SHALL be one sub-module, instr_pack, outputting word and legal flag.

Verification
REQ-030 ADD rd=3 rs1=1 rs2=2 scalar=1, ready high -> data=(OPCODE_R<<29)|0x10008023 at addr 0, valid one cycle after accept, instr_count=1.
REQ-031 ADDI rd=1 rs1=2 imm=-1 scalar=0 -> (OPCODE_I<<29)|0x0FFFC041; then imm=8192 -> err_illegal pulse, no write, address unchanged.
REQ-032 LUI rd=4 imm=0x12345000 scalar=1 -> (OPCODE_UP<<29)|0x02468A24.
REQ-033 mem_write_ready low 3 cycles -> valid, address, data stable; in_ready=0 throughout; single write.
REQ-034 load_addr=0xFF with request, then second request -> writes at 0xFF then 0x00.
REQ-035 reset asserted in WRITE -> next cycle valid=0, address=0, instr_count=0.
